storage_layer_mc: RTL

- Parametrised single-clock sample buffer between the acquisition front end and the USB/host read-out.
- Two modes, selected by MODE:
  - oscilloscope: raw DATA_W-bit samples.
  - Doppler: complex {IM, RE} pairs of CPX_W bits each.
- Adds configurable depth and thresholds, a fill/drain hysteresis FSM driving READY2WRITE/READY2READ, registered read data with a valid strobe, sticky overflow/underflow flags, and an automatic flush on mode change.

---
 rtl/storage_layer_mc_pkg.sv | 19 +
 rtl/storage_layer_mc_fifo.sv | 68 ++++++
 rtl/storage_layer_mc.sv | 119 +++++++++++
 3 files changed

// File: rtl/storage_layer_mc_pkg.sv
// Shared mode codes, FSM encodings and default widths for the acquisition sample buffer.
package storage_layer_mc_pkg;

  localparam logic OSZI_MODE = 1'b1;
  localparam logic DOP_MODE  = 1'b0;

  localparam logic [0:0] ST_FILL  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_CPX_W  = 32;
  localparam int DEF_DEPTH  = 512;

  // Width of a fill counter that must hold the value DEPTH itself.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/storage_layer_mc_fifo.sv
// Single-clock FIFO core: memory array, wrapping pointers, fill count and registered read port.
module sync_fifo_core #(
  parameter int W     = 64,
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [W-1:0]             wr_data,
  output logic [W-1:0]             rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_ok;
  logic          rd_ok;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign wr_ok = wr_en & ~full & ~flush;
  assign rd_ok = rd_en & ~empty & ~flush;

  // No reset on the array so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      if (rd_ok) begin
        rd_data <= mem[rd_ptr];
      end
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (wr_ok) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (rd_ok) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        level <= level + LW'(wr_ok) - LW'(rd_ok);
      end
    end
  end

endmodule

// File: rtl/storage_layer_mc.sv
// Sample buffer between acquisition front end and host read-out: mode mux, flush on mode
// change, fill/drain hysteresis and sticky error flags around a sync FIFO core.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_FILL  | producer may write (READY2WRITE=1), host should wait
// ST_DRAIN | host may read (READY2READ=1), producer should pause
module storage_layer_mc
  import storage_layer_mc_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int CPX_W    = DEF_CPX_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 16,
  parameter int AE_LEVEL = 16,
  parameter int MEM_W    = 2 * CPX_W
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   MODE,
  input  logic                   ENABLE,
  input  logic                   WRITE,
  input  logic                   READ,
  input  logic [DATA_W-1:0]      DIN,
  input  logic [CPX_W-1:0]       RE_IN,
  input  logic [CPX_W-1:0]       IM_IN,
  output logic [MEM_W-1:0]       DOUT,
  output logic                   DOUT_VALID,
  output logic                   READY2READ,
  output logic                   READY2WRITE,
  output logic [$clog2(DEPTH):0] LEVEL,
  output logic                   OVERFLOW,
  output logic                   UNDERFLOW
);

  localparam int LW = level_w(DEPTH);

  logic             mode_q;
  logic             flush;
  logic             full;
  logic             empty;
  logic             wr;
  logic             rd;
  logic [MEM_W-1:0] wr_word;
  logic [LW-1:0]    next_level;
  logic [0:0]       state;
  logic [0:0]       state_nxt;

  assign flush = (MODE != mode_q);
  assign wr    = ENABLE & WRITE & ~full & ~flush;
  assign rd    = ENABLE & READ & ~empty & ~flush;

  assign wr_word = (MODE == OSZI_MODE) ? MEM_W'(DIN) : MEM_W'({IM_IN, RE_IN});

  sync_fifo_core #(
    .W     (MEM_W),
    .DEPTH (DEPTH)
  ) u_core (
    .clk      (CLK),
    .reset    (RESET),
    .flush    (flush),
    .wr_en    (wr),
    .rd_en    (rd),
    .wr_data  (wr_word),
    .rd_data  (DOUT),
    .rd_valid (DOUT_VALID),
    .level    (LEVEL),
    .full     (full),
    .empty    (empty)
  );

  // Thresholds are judged on the post-edge level so the ready outputs flip on the crossing edge.
  assign next_level = flush ? '0 : (LEVEL + LW'(wr) - LW'(rd));

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_FILL;
    end else if (state == ST_FILL) begin
      if (next_level >= LW'(AF_LEVEL)) begin
        state_nxt = ST_DRAIN;
      end
    end else begin
      if (next_level <= LW'(AE_LEVEL)) begin
        state_nxt = ST_FILL;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= ST_FILL;
      READY2WRITE <= 1'b1;
      READY2READ  <= 1'b0;
      mode_q      <= MODE;
    end else begin
      state       <= state_nxt;
      READY2WRITE <= (state_nxt == ST_FILL);
      READY2READ  <= (state_nxt == ST_DRAIN);
      mode_q      <= MODE;
    end
  end

  // Flags only record attempts the buffer actually considered; flush cycles are ignored.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      if (ENABLE & WRITE & full & ~flush) begin
        OVERFLOW <= 1'b1;
      end
      if (ENABLE & READ & empty & ~flush) begin
        UNDERFLOW <= 1'b1;
      end
    end
  end

endmodule
